// File: rtl/regfile.sv
// 32 x WIDTH-bit LEGv8 register file: two combinational read ports with same-cycle
// write bypass, one synchronous write port, X31 (XZR) hardwired to zero.
module regfile #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] XZR = 5'd31;

  logic [WIDTH-1:0] regs [0:NREGS-2];
  logic [WIDTH-1:0] read_view [0:NREGS-1];
  logic [NREGS-1:0] write_en;
  logic             bypass1;
  logic             bypass2;

  // One-hot write decode; index 31 never gets an enable since XZR has no storage.
  always_comb begin
    write_en = '0;
    if (RegWrite && (WriteRegister != XZR))
      write_en[WriteRegister] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS - 1; i++) begin
      if (reset)
        regs[i] <= '0;
      else if (write_en[i])
        regs[i] <= WriteData;
    end
  end

  // Present XZR as a constant-zero mux input alongside the stored registers.
  always_comb begin
    for (int i = 0; i < NREGS - 1; i++)
      read_view[i] = regs[i];
    read_view[NREGS-1] = '0;
  end

  always_comb begin
    bypass1 = RegWrite && !reset && (WriteRegister == ReadRegister1) && (ReadRegister1 != XZR);
    bypass2 = RegWrite && !reset && (WriteRegister == ReadRegister2) && (ReadRegister2 != XZR);
  end

  always_comb begin
    ReadData1 = bypass1 ? WriteData : read_view[ReadRegister1];
    ReadData2 = bypass2 ? WriteData : read_view[ReadRegister2];
  end

endmodule
